temporal_encoder: RTL and testbench

Downstream neighbour of the spatial encoder. It consumes the stream of per-sample spatial hypervectors and forms an N-gram hypervector over a sliding window of the last ngram_size inputs, using permute-and-bind. The newest HV is XORed with the previous HV rotated left by 1, the one before rotated left by 2, and so on. The result feeds the associative memory (classifier) stage through a valid/ready handshake.

---
 rtl/temporal_encoder_pkg.sv | 20 ++
 rtl/temporal_encoder_hv_rotate.sv | 17 +
 rtl/temporal_encoder.sv | 116 +++++++++++
 tb/tb_temporal_encoder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/temporal_encoder_pkg.sv
// rtl/temporal_encoder_pkg.sv - shared sizing constants and helpers for the temporal encoder
package temporal_encoder_pkg;

    // Hypervector width shared with the spatial encoder and the associative memory.
    localparam int HV_DIMENSION = 64;

    // Default N-gram window length, so the encoder and the classifier agree.
    localparam int NGRAM_SIZE = 3;

    // Smallest r such that 2**r >= value.
    function automatic int ceil_log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/temporal_encoder_hv_rotate.sv
// rtl/temporal_encoder_hv_rotate.sv - fixed circular left rotate of a hypervector
//
// Purpose: pure wiring; bit i of i_data lands on bit (i + shift) mod width.
// Ports:
//   i_data  input  [width-1:0]  hypervector to rotate
//   o_data  output [width-1:0]  rotated hypervector
module temporal_encoder_hv_rotate #(
    parameter int shift = 1,
    parameter int width = 64
) (
    input  logic [width-1:0] i_data,
    output logic [width-1:0] o_data
);

    assign o_data = {i_data[width-1-shift:0], i_data[width-1:width-shift]};

endmodule

// File: rtl/temporal_encoder.sv
// rtl/temporal_encoder.sv - sliding-window permute-and-bind N-gram encoder
//
// Purpose: keeps the last ngram_size-1 accepted hypervectors and, once the
// window is full, emits hvin ^ rotl(history[1],1) ^ ... ^ rotl(history[N-1],N-1)
// for every accepted input, one cycle after acceptance.
// Ports:
//   clk          input   clock
//   rst          input   synchronous active-high reset
//   din_valid    input   upstream hypervector valid
//   din_ready    output  an input can be accepted this cycle
//   hvin         input   spatial hypervector
//   clear        input   one-cycle pulse: empty the window
//   hvout_valid  output  N-gram hypervector valid
//   hvout_ready  input   downstream accepts hvout
//   hvout        output  N-gram hypervector (registered)
module temporal_encoder
    import temporal_encoder_pkg::*;
#(
    parameter int ngram_size = NGRAM_SIZE,
    parameter int hv_dim     = HV_DIMENSION
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [hv_dim-1:0] hvin,
    input  logic              clear,
    output logic              hvout_valid,
    input  logic              hvout_ready,
    output logic [hv_dim-1:0] hvout
);

    localparam int CNT_W = ceil_log2(ngram_size);

    generate
        if (ngram_size < 2 || ngram_size > 16) begin : g_bad_ngram
            $error("temporal_encoder: ngram_size must be in 2..16");
        end
    endgenerate

    logic [hv_dim-1:0] r_history [1:ngram_size-1];
    logic [CNT_W-1:0]  r_fill_count;
    logic              r_hvout_valid;
    logic [hv_dim-1:0] r_hvout;

    logic [hv_dim-1:0] w_rot [1:ngram_size-1];
    logic [hv_dim-1:0] w_ngram;
    logic              w_din_fire;
    logic              w_hvout_fire;
    logic              w_window_full;

    // Output register gates input: at most one N-gram in flight, so the
    // ready path never depends combinationally on hvout_ready.
    assign din_ready     = !r_hvout_valid && !clear;
    assign w_din_fire    = din_valid && din_ready;
    assign w_hvout_fire  = r_hvout_valid && hvout_ready;
    assign w_window_full = (r_fill_count == CNT_W'(ngram_size - 1));

    assign hvout_valid = r_hvout_valid;
    assign hvout       = r_hvout;

    // Older samples get a larger rotation so position in the window is encoded.
    genvar k;
    generate
        for (k = 1; k < ngram_size; k++) begin : g_tap
            temporal_encoder_hv_rotate #(
                .shift (k),
                .width (hv_dim)
            ) u_rot (
                .i_data (r_history[k]),
                .o_data (w_rot[k])
            );
        end
    endgenerate

    always_comb begin
        w_ngram = hvin;
        for (int i = 1; i < ngram_size; i++) begin
            w_ngram = w_ngram ^ w_rot[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hvout_valid <= 1'b0;
            r_hvout       <= '0;
            r_fill_count  <= '0;
            for (int i = 1; i < ngram_size; i++) begin
                r_history[i] <= '0;
            end
        end else begin
            if (w_hvout_fire) begin
                r_hvout_valid <= 1'b0;
            end
            // clear empties the window but leaves a pending output intact.
            if (clear) begin
                r_fill_count <= '0;
                for (int i = 1; i < ngram_size; i++) begin
                    r_history[i] <= '0;
                end
            end else if (w_din_fire) begin
                for (int i = ngram_size - 1; i >= 2; i--) begin
                    r_history[i] <= r_history[i-1];
                end
                r_history[1] <= hvin;
                if (w_window_full) begin
                    r_hvout       <= w_ngram;
                    r_hvout_valid <= 1'b1;
                end else begin
                    r_fill_count <= r_fill_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_temporal_encoder.sv
// tb/tb_temporal_encoder.sv - directed self-checking bench for temporal_encoder
module tb_temporal_encoder;

    localparam int W = 64;

    logic         clk;
    logic         rst;
    logic         din_valid;
    logic         din_ready;
    logic [W-1:0] hvin;
    logic         clear;
    logic         hvout_valid;
    logic         hvout_ready;
    logic [W-1:0] hvout;

    int n_pass;
    int n_total;
    int n_fire;

    temporal_encoder #(
        .ngram_size (3),
        .hv_dim     (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .hvin        (hvin),
        .clear       (clear),
        .hvout_valid (hvout_valid),
        .hvout_ready (hvout_ready),
        .hvout       (hvout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after posedge, so negedge sees a stable handshake.
    always @(negedge clk) begin
        if (!rst && hvout_valid && hvout_ready) n_fire = n_fire + 1;
    end

    function automatic logic [W-1:0] bit_hv(input int idx);
        logic [W-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one HV and wait (bounded) until it is consumed.
    task automatic send(input logic [W-1:0] hv);
        bit done;
        done = 1'b0;
        din_valid = 1'b1;
        hvin = hv;
        for (int c = 0; c < 50 && !done; c++) begin
            if (din_ready) done = 1'b1;
            step();
        end
        din_valid = 1'b0;
        n_total++;
        if (!done) $display("FAIL send_timeout: din_ready never rose, required 1");
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        n_fire = 0;
        n_total++;
        if (hvout_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", hvout_valid);
        else n_pass++;
        n_total++;
        if (hvout !== '0) $display("FAIL reset_hvout: got %h required 0", hvout);
        else n_pass++;
        n_total++;
        if (din_ready !== 1'b1) $display("FAIL reset_din_ready: got %b required 1", din_ready);
        else n_pass++;
    endtask

    task automatic test_warmup();
        hvout_ready = 1'b1;
        send(bit_hv(0));
        n_total++;
        if (hvout_valid !== 1'b0) $display("FAIL warmup_a_valid: got %b required 0", hvout_valid);
        else n_pass++;
        send(bit_hv(0));
        n_total++;
        if (hvout_valid !== 1'b0) $display("FAIL warmup_b_valid: got %b required 0", hvout_valid);
        else n_pass++;
        send('0);
        n_total++;
        if (hvout_valid !== 1'b1) $display("FAIL first_valid: got %b required 1", hvout_valid);
        else n_pass++;
        n_total++;
        if (hvout !== 64'h6) $display("FAIL first_hvout: got %h required %h", hvout, 64'h6);
        else n_pass++;
    endtask

    task automatic test_sliding();
        send(bit_hv(5));
        n_total++;
        if (hvout_valid !== 1'b1 || hvout !== 64'h24)
            $display("FAIL sliding_hvout: got v=%b %h required v=1 %h", hvout_valid, hvout, 64'h24);
        else n_pass++;
        step();
        n_total++;
        if (n_fire !== 2) $display("FAIL sliding_count: got %0d outputs required 2", n_fire);
        else n_pass++;
    endtask

    task automatic test_wrap();
        send(bit_hv(W-1));
        n_total++;
        if (hvout !== 64'h8000_0000_0000_0040)
            $display("FAIL wrap_first: got %h required %h", hvout, 64'h8000_0000_0000_0040);
        else n_pass++;
        send(bit_hv(W-1));
        send(bit_hv(W-1));
        n_total++;
        if (hvout_valid !== 1'b1 || hvout !== 64'h8000_0000_0000_0003)
            $display("FAIL wrap_hvout: got v=%b %h required v=1 %h", hvout_valid, hvout, 64'h8000_0000_0000_0003);
        else n_pass++;
        step();
    endtask

    task automatic test_backpressure();
        int fires_before;
        bit stable_ok;
        bit ready_ok;
        fires_before = n_fire;
        hvout_ready = 1'b0;
        send(bit_hv(10));
        n_total++;
        if (hvout !== 64'h403) $display("FAIL bp_hvout: got %h required %h", hvout, 64'h403);
        else n_pass++;
        din_valid = 1'b1;
        hvin = bit_hv(20);
        stable_ok = 1'b1;
        ready_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (hvout !== 64'h403 || hvout_valid !== 1'b1) stable_ok = 1'b0;
            if (din_ready !== 1'b0) ready_ok = 1'b0;
            step();
        end
        n_total++;
        if (!stable_ok) $display("FAIL bp_hold: got %h v=%b required held %h", hvout, hvout_valid, 64'h403);
        else n_pass++;
        n_total++;
        if (!ready_ok) $display("FAIL bp_din_ready: got 1 while stalled required 0");
        else n_pass++;
        hvout_ready = 1'b1;
        step();
        n_total++;
        if (din_ready !== 1'b1) $display("FAIL bp_release_ready: got %b required 1", din_ready);
        else n_pass++;
        step();
        din_valid = 1'b0;
        n_total++;
        if (hvout_valid !== 1'b1 || hvout !== 64'h0010_0802)
            $display("FAIL bp_next_hvout: got v=%b %h required v=1 %h", hvout_valid, hvout, 64'h0010_0802);
        else n_pass++;
        step();
        step();
        n_total++;
        if (n_fire - fires_before !== 2)
            $display("FAIL bp_fire_count: got %0d required 2", n_fire - fires_before);
        else n_pass++;
    endtask

    task automatic test_clear();
        int fires_before;
        hvout_ready = 1'b0;
        send(bit_hv(30));
        fires_before = n_fire;
        clear = 1'b1;
        din_valid = 1'b1;
        hvin = bit_hv(40);
        #1;
        n_total++;
        if (din_ready !== 1'b0) $display("FAIL clear_din_ready: got %b required 0", din_ready);
        else n_pass++;
        step();
        clear = 1'b0;
        din_valid = 1'b0;
        n_total++;
        if (hvout_valid !== 1'b1 || hvout !== 64'h4020_1000)
            $display("FAIL clear_pending: got v=%b %h required v=1 %h", hvout_valid, hvout, 64'h4020_1000);
        else n_pass++;
        hvout_ready = 1'b1;
        step();
        n_total++;
        if (n_fire - fires_before !== 1)
            $display("FAIL clear_delivered: got %0d fires required 1", n_fire - fires_before);
        else n_pass++;
        send(bit_hv(0));
        n_total++;
        if (hvout_valid !== 1'b0) $display("FAIL clear_warm1: got %b required 0", hvout_valid);
        else n_pass++;
        send(bit_hv(8));
        n_total++;
        if (hvout_valid !== 1'b0) $display("FAIL clear_warm2: got %b required 0", hvout_valid);
        else n_pass++;
        send(bit_hv(16));
        n_total++;
        if (hvout_valid !== 1'b1 || hvout !== 64'h1_0204)
            $display("FAIL clear_first: got v=%b %h required v=1 %h", hvout_valid, hvout, 64'h1_0204);
        else n_pass++;
        step();
    endtask

    task automatic test_reset_mid();
        hvout_ready = 1'b0;
        send(bit_hv(4));
        n_total++;
        if (hvout_valid !== 1'b1) $display("FAIL rmid_pending: got %b required 1", hvout_valid);
        else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_total++;
        if (hvout_valid !== 1'b0 || hvout !== '0)
            $display("FAIL rmid_cleared: got v=%b %h required v=0 0", hvout_valid, hvout);
        else n_pass++;
        hvout_ready = 1'b1;
        send(bit_hv(0));
        send(bit_hv(0));
        n_total++;
        if (hvout_valid !== 1'b0) $display("FAIL rmid_warm: got %b required 0", hvout_valid);
        else n_pass++;
        send('0);
        n_total++;
        if (hvout_valid !== 1'b1 || hvout !== 64'h6)
            $display("FAIL rmid_first: got v=%b %h required v=1 %h", hvout_valid, hvout, 64'h6);
        else n_pass++;
        step();
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        n_fire = 0;
        rst = 1'b1;
        din_valid = 1'b0;
        hvin = '0;
        clear = 1'b0;
        hvout_ready = 1'b0;
        test_reset();
        test_warmup();
        test_sliding();
        test_wrap();
        test_backpressure();
        test_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
